// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   PC_W, INSTR_W, IMEM_AW : default widths for the fetch path
//   fetch_state_t          : fetch FSM state encoding
package cpu_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int IMEM_AW = 8;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small decoupling FIFO for fetched {instr, pc} entries.
// Entries shift toward slot 0, so the head is always a plain register (mem[0]).
// Ports:
//   clock, reset_n  rising-edge clock, async active-low reset
//   push/push_data  write one entry (caller guarantees not full)
//   pop             remove head entry (ignored when empty)
//   flush           drop all entries; wins over push/pop
//   count           current occupancy, 0..DEPTH
//   head_valid      FIFO not empty
//   head_data       entry at the head
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [W-1:0]             head_data
);
    import cpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic          do_pop;
    logic [IW-1:0] wr_idx;

    assign head_valid = (count != '0);
    assign head_data  = mem[0];
    assign do_pop     = pop && head_valid;

    // A simultaneous pop shifts everything down one slot, so the new entry
    // lands one position lower.
    always_comb begin
        wr_idx = IW'(count);
        if (do_pop) begin
            wr_idx = IW'(count - CW'(1));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (push) begin
                mem[wr_idx] <= push_data;
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a synchronous instruction
// memory, tags returned words with their PC and queues them for decode.
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched/perf_flushed).
// Ports:
//   clock, reset_n   rising-edge clock, async active-low reset
//   imem_en          memory read strobe (data returns next cycle)
//   imem_addr        word address, low IMEM_AW bits of fetch_pc
//   imem_data        memory read data
//   redirect_valid   load redirect_pc and flush all wrong-path work
//   redirect_pc      new fetch PC (word address)
//   out_valid        out_instr/out_pc hold a valid entry
//   out_ready        decode accepts the head entry
//   out_instr        instruction at the queue head
//   out_pc           PC of out_instr
//   perf_fetched     (FETCH_PERF_CNT_EN) saturating count of queued words
//   perf_flushed     (FETCH_PERF_CNT_EN) saturating count of discarded words
//
// state  | meaning
// S_BOOT | first cycle after reset, no memory request
// S_RUN  | normal fetching, held until reset
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter int          IMEM_AW  = cpu_pkg::IMEM_AW,
    parameter int          INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    output logic                       imem_en,
    output logic [IMEM_AW-1:0]         imem_addr,
    input  logic [INSTR_W-1:0]         imem_data,
    input  logic                       redirect_valid,
    input  logic [cpu_pkg::PC_W-1:0]   redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [cpu_pkg::PC_W-1:0]   out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_flushed
`endif
);
    import cpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INSTR_W + PC_W;

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Credit check counts the in-flight response as already occupying a slot,
    // so a response can always be pushed without a full check.
    always_comb begin
        state_next = state;
        imem_en    = 1'b0;
        case (state)
            S_BOOT: state_next = S_RUN;
            S_RUN:  imem_en = !redirect_valid &&
                              ((count + CW'(inflight)) < CW'(DEPTH));
            default: state_next = S_BOOT;
        endcase
    end

    assign imem_addr = fetch_pc[IMEM_AW-1:0];
    assign push      = inflight && !redirect_valid;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  ({imem_data, inflight_pc}),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head_valid (out_valid),
        .head_data  (head_data)
    );

    assign out_instr = head_data[EW-1:PC_W];
    assign out_pc    = head_data[PC_W-1:0];

`ifdef FETCH_PERF_CNT_EN
    // An entry handed to decode in the redirect cycle was consumed, not
    // discarded, so it is excluded from the flushed total.
    logic [CW-1:0] flushed_now;
    logic [32:0]   flushed_sum;

    assign flushed_now = count - CW'(pop) + CW'(inflight);
    assign flushed_sum = {1'b0, perf_flushed} + 33'(flushed_now);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 1'b1;
            end
            if (redirect_valid) begin
                perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The reference model reasons about the
// visible instruction stream: decode must see consecutive PCs starting at the
// last redirect target (or reset PC), and out_valid must be high from the
// third cycle after any redirect or reset release onward.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .IMEM_AW  (8),
        .INSTR_W  (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    always #5 clock = ~clock;

    logic [31:0] imem [256];
    int          n_tests = 0;
    int          n_fail = 0;
    int          age = 0;
    int          issue_cnt = 0;
    logic [31:0] exp_pc = '0;
    logic [31:0] fetch_exp = '0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;
    logic        prev_stall = 1'b0;
    logic        pend = 1'b0;
    logic [7:0]  pend_addr = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, sample 1ns later.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clock);
        imem_data      = pend ? imem[pend_addr] : $urandom();
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        check("out_valid", 64'(out_valid), 64'(age >= 3));
        if (prev_stall) begin
            check("hold_pc", 64'(out_pc), 64'(prev_pc));
            check("hold_instr", 64'(out_instr), 64'(prev_instr));
        end
        if (rv) begin
            check("imem_en_on_redirect", 64'(imem_en), 64'(0));
        end
        pend = imem_en;
        pend_addr = imem_addr;
        if (imem_en) begin
            check("imem_addr", 64'(imem_addr), 64'(fetch_exp[7:0]));
            fetch_exp++;
            issue_cnt++;
        end
        if (out_valid && rdy) begin
            check("out_pc", 64'(out_pc), 64'(exp_pc));
            check("out_instr", 64'(out_instr), 64'(imem[exp_pc[7:0]]));
            exp_pc++;
        end
        prev_stall = out_valid && !rdy && !rv;
        prev_pc    = out_pc;
        prev_instr = out_instr;
        if (rv) begin
            exp_pc    = rpc;
            fetch_exp = rpc;
            age       = 1;
        end else begin
            age++;
        end
    endtask

    // Assert reset between clock edges, check outputs clear at once, then
    // release on a falling edge; that cycle is the BOOT cycle.
    task automatic do_reset(input logic brv, input logic [31:0] bpc);
        @(negedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_imem_en", 64'(imem_en), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_instr", 64'(out_instr), 64'(0));
        check("rst_out_pc", 64'(out_pc), 64'(0));
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetched", 64'(perf_fetched), 64'(0));
        check("rst_perf_flushed", 64'(perf_flushed), 64'(0));
`endif
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        pend           = 1'b0;
        repeat (2) @(negedge clock);
        reset_n        = 1'b1;
        redirect_valid = brv;
        redirect_pc    = bpc;
        #1;
        check("boot_imem_en", 64'(imem_en), 64'(0));
        check("boot_out_valid", 64'(out_valid), 64'(0));
        prev_stall = 1'b0;
        age        = 1;
        exp_pc     = brv ? bpc : RESET_PC;
        fetch_exp  = exp_pc;
        issue_cnt  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'hA000_0000 + 32'(i);
        end

        // Streaming from reset: first word visible in cycle 3, one per cycle.
        do_reset(1'b0, '0);
        repeat (15) cycle(1'b1, 1'b0, '0);

        // Async reset mid-stream, then stall for 10 cycles.
        do_reset(1'b0, '0);
        repeat (10) cycle(1'b0, 1'b0, '0);
        check("stall_issue_count", 64'(issue_cnt), 64'(DEPTH));
        check("stall_imem_en", 64'(imem_en), 64'(0));
        repeat (8) cycle(1'b1, 1'b0, '0);

        // Redirect with 3 queued entries plus one response in flight.
        do_reset(1'b0, '0);
        repeat (4) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h40);
        repeat (8) cycle(1'b1, 1'b0, '0);

        // Redirect in the same cycle PC 5 is popped.
        do_reset(1'b0, '0);
        repeat (7) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h40);
        repeat (6) cycle(1'b1, 1'b0, '0);

        // Memory address wrap, full 32-bit PC wrap, back-to-back redirects.
        cycle(1'b1, 1'b1, 32'hFE);
        repeat (6) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFE);
        repeat (6) cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h10);
        cycle(1'b1, 1'b1, 32'h80);
        repeat (6) cycle(1'b1, 1'b0, '0);

        // Redirect during the BOOT cycle.
        do_reset(1'b1, 32'h33);
        repeat (6) cycle(1'b1, 1'b0, '0);

        // Random memory contents, backpressure and redirects.
        for (int i = 0; i < 256; i++) begin
            imem[i] = $urandom();
        end
        do_reset(1'b0, '0);
        repeat (400) begin
            cycle($urandom_range(3) != 0, $urandom_range(19) == 0, $urandom());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
